// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Latency: WIDTH+1 edges from accept to the DONE edge; divide-by-zero and signed overflow finish on the accept edge.
// Backpressure: ready is high only in IDLE; valid is ignored while busy, there is no queue; kill aborts or blocks an op.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   valid_i/ready_o  request handshake; accept on an edge where both are high and kill_i is low
//   kill_i           pipeline flush; drops the in-flight op, and blocks an accept on the same edge
//   funct3           0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   op_a, op_b       rs1/rs2, sampled only at accept
//   valid_o, result  one-cycle result strobe; result holds until the next strobe

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             kill_i,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             valid_o,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               iter_done;   // all WIDTH iterations applied; next CALC edge writes the result
    logic [2:0]         op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   opnd;        // multiplicand |a| or divisor |b|
    logic [2*WIDTH-1:0] acc;         // mul: {product hi, multiplier}; div: {remainder, dividend/quotient}

    // ---------------- accept-side decode ----------------
    logic             is_div;
    logic             a_signed;
    logic             b_signed;
    logic             a_neg_in;
    logic             b_neg_in;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        is_div   = funct3[2];
        a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                   (funct3 == F_DIV)  || (funct3 == F_REM);
        b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
        a_neg_in = a_signed & op_a[WIDTH-1];
        b_neg_in = b_signed & op_b[WIDTH-1];
        a_abs    = a_neg_in ? (~op_a + 1'b1) : op_a;
        b_abs    = b_neg_in ? (~op_b + 1'b1) : op_b;
        div_zero = is_div && (op_b == '0);
        // Only signed divide/remainder can overflow; funct3[0]==0 selects DIV/REM.
        div_ovf  = is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == ALL_ONES);
        // funct3[1] distinguishes REM/REMU from DIV/DIVU.
        if (funct3[1]) begin
            special_res = div_zero ? op_a : '0;
        end else begin
            special_res = div_zero ? ALL_ONES : MIN_NEG;
        end
    end

    // ---------------- one iteration of each algorithm ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;

    always_comb begin
        // Multiply: conditional add into the upper half, carry kept as the new MSB after the shift.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

        // Restoring divide: shift {rem, dividend} left, trial-subtract; a clear borrow bit means it fits.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (div_diff[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end

        step_next = op[2] ? div_next : mul_next;
    end

    // ---------------- sign correction and result select ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   final_res;

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
        quo_fix  = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        // Remainder follows the dividend's sign only.
        rem_fix  = sign_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        case (op)
            F_MUL:                     final_res = prod_fix[WIDTH-1:0];
            F_MULH, F_MULHSU, F_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
            F_DIV, F_DIVU:             final_res = quo_fix;
            F_REM, F_REMU:             final_res = rem_fix;
            default:                   final_res = '0;
        endcase
    end

    // ---------------- control FSM with registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ready_o   <= 1'b1;
            valid_o   <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            iter_done <= 1'b0;
            op        <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            opnd      <= '0;
            acc       <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_i && !kill_i) begin
                        op        <= funct3;
                        sign_a    <= a_neg_in;
                        sign_b    <= b_neg_in;
                        cnt       <= '0;
                        iter_done <= 1'b0;
                        ready_o   <= 1'b0;
                        if (div_zero || div_ovf) begin
                            result  <= special_res;
                            valid_o <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            opnd  <= is_div ? b_abs : a_abs;
                            acc   <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (kill_i) begin
                        state   <= S_IDLE;
                        ready_o <= 1'b1;
                    end else if (iter_done) begin
                        result  <= final_res;
                        valid_o <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        acc <= step_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_ITER) begin
                            iter_done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops vs an arithmetic model,
// and hand-written kill / hold-off / mid-operation reset sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        kill_i = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        valid_o;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res = 32'd0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .kill_i  (kill_i),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .valid_o (valid_o),
        .result  (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M semantics from 64-bit integer arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint p;
        int qa = $signed(a);
        int qb = $signed(b);
        logic [31:0] r;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else r = qa / qb;
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                else r = qa % qb;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit fast = f3[2] && ((b == 0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
        return fast ? 0 : 33;
    endfunction

    // Issue one op starting #1 after an edge; ends #1 after the edge following the valid_o pulse.
    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int k = 0;
        logic busy_bad = 1'b0;
        chk({name, "_ready_before"}, 32'(ready_o), 32'd1);
        funct3  = f3;
        op_a    = a;
        op_b    = b;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        op_a    = $urandom;
        op_b    = $urandom;
        if (ready_o) busy_bad = 1'b1;
        while (!valid_o && k < 60) begin
            @(posedge clk); #1;
            k++;
            if (ready_o) busy_bad = 1'b1;
        end
        chk({name, "_latency"}, 32'(k), 32'(exp_lat));
        chk({name, "_result"}, result, exp_res);
        chk({name, "_busy_ready"}, 32'(busy_bad), 32'd0);
        @(posedge clk); #1;
        chk({name, "_pulse_end"}, {30'd0, valid_o, ready_o}, 32'd1);
        last_res = exp_res;
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int pulses;
        int accepts;

        vecs.push_back('{"mul_7x6",      3'd0, 32'd7,          32'd6,          32'd42,         33});
        vecs.push_back('{"mulh_m1m1",    3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   33});
        vecs.push_back('{"mulhu_max",    3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   33});
        vecs.push_back('{"mulhsu_max",   3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   33});
        vecs.push_back('{"mul_min_x2",   3'd0, 32'h80000000,   32'd2,          32'h00000000,   33});
        vecs.push_back('{"div_m7_2",     3'd4, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33});
        vecs.push_back('{"rem_m7_2",     3'd6, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33});
        vecs.push_back('{"divu_max_16",  3'd5, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   33});
        vecs.push_back('{"remu_100_7",   3'd7, 32'd100,        32'd7,          32'd2,          33});
        vecs.push_back('{"rem_7_m2",     3'd6, 32'd7,          32'hFFFFFFFE,   32'd1,          33});
        vecs.push_back('{"divu_min_m1",  3'd5, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33});
        vecs.push_back('{"mul_x0",       3'd0, 32'h1234,       32'd0,          32'd0,          33});
        vecs.push_back('{"div_by0",      3'd4, 32'h1234,       32'd0,          32'hFFFFFFFF,   0});
        vecs.push_back('{"divu_by0",     3'd5, 32'h1234,       32'd0,          32'hFFFFFFFF,   0});
        vecs.push_back('{"rem_by0",      3'd6, 32'h1234,       32'd0,          32'h1234,       0});
        vecs.push_back('{"remu_by0",     3'd7, 32'h1234,       32'd0,          32'h1234,       0});
        vecs.push_back('{"div_ovf",      3'd4, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   0});
        vecs.push_back('{"rem_ovf",      3'd6, 32'h80000000,   32'hFFFFFFFF,   32'd0,          0});

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_ready", 32'(ready_o), 32'd1);
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_result", result, 32'd0);

        // Directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
        end

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom;
            logic [31:0] b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            do_op("rand", f3, a, b, ref_res(f3, a, b), ref_lat(f3, a, b));
        end

        // Kill at iteration 10 of a DIVU: back to IDLE, no strobe, result untouched
        funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        chk("kill_ready", 32'(ready_o), 32'd1);
        chk("kill_valid", 32'(valid_o), 32'd0);
        chk("kill_result", result, last_res);
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_o) pulses++; end
        chk("kill_no_pulse", 32'(pulses), 32'd0);

        // Kill in IDLE blocks the accept
        funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; valid_i = 1'b1; kill_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        chk("idle_kill_ready", 32'(ready_o), 32'd1);
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_o) pulses++; end
        chk("idle_kill_no_pulse", 32'(pulses), 32'd0);

        // valid_i held high: one accept per op, ops spaced 35 edges apart
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; valid_i = 1'b1;
        pulses = 0; accepts = 0;
        for (int i = 0; i < 100; i++) begin
            if (ready_o) accepts++;
            @(posedge clk); #1;
            if (valid_o) begin
                pulses++;
                chk("hold_result", result, 32'd15);
            end
        end
        valid_i = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_o) begin
                pulses++;
                chk("hold_result", result, 32'd15);
            end
        end
        chk("hold_accepts", 32'(accepts), 32'd3);
        chk("hold_pulses", 32'(pulses), 32'(accepts));
        last_res = 32'd15;

        // Asynchronous reset mid-CALC
        funct3 = 3'd5; op_a = 32'd5000; op_b = 32'd7; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready_o), 32'd1);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_result", result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_o) pulses++; end
        chk("midrst_no_pulse", 32'(pulses), 32'd0);
        do_op("post_reset_mul", 3'd0, 32'd7, 32'd6, 32'd42, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
